// File: rtl/md_unit_e_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: operation codes,
// FSM states and op-class helpers.
package md_unit_e_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } md_state_e;

  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_unit_e_calc.sv
// Combinational multiply/divide datapath producing {HI, LO}, including the
// divide-by-zero and signed-overflow results.
module md_unit_e_calc
  import md_unit_e_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   rs_i,
  input  logic [WIDTH-1:0]   rt_i,
  output logic [2*WIDTH-1:0] res_o
);

  logic signed [2*WIDTH-1:0] rs_sx, rt_sx, prod_s;
  logic [2*WIDTH-1:0]        prod_u;
  logic                      sgn_div, rs_neg, rt_neg;
  logic [WIDTH-1:0]          rs_mag, rt_mag, den, q_mag, r_mag, quot, rem;

  assign rs_sx  = {{WIDTH{rs_i[WIDTH-1]}}, rs_i};
  assign rt_sx  = {{WIDTH{rt_i[WIDTH-1]}}, rt_i};
  assign prod_s = rs_sx * rt_sx;
  assign prod_u = {{WIDTH{1'b0}}, rs_i} * {{WIDTH{1'b0}}, rt_i};

  // Signed divide works on magnitudes; the most-negative dividend keeps its
  // bit pattern as an unsigned magnitude, so the -1 overflow case falls out
  // naturally as quotient = rs, remainder = 0.
  assign sgn_div = (op_i == MD_DIV);
  assign rs_neg  = sgn_div & rs_i[WIDTH-1];
  assign rt_neg  = sgn_div & rt_i[WIDTH-1];
  assign rs_mag  = rs_neg ? -rs_i : rs_i;
  assign rt_mag  = rt_neg ? -rt_i : rt_i;
  assign den     = (rt_i == '0) ? WIDTH'(1) : rt_mag;
  assign q_mag   = rs_mag / den;
  assign r_mag   = rs_mag % den;
  assign quot    = (rs_neg ^ rt_neg) ? -q_mag : q_mag;
  assign rem     = rs_neg ? -r_mag : r_mag;

  always_comb begin
    res_o = '0;
    case (op_i)
      MD_MULT:  res_o = prod_s;
      MD_MULTU: res_o = prod_u;
      MD_DIV, MD_DIVU: begin
        if (rt_i == '0) res_o = {rs_i, {WIDTH{1'b1}}};
        else            res_o = {rem, quot};
      end
      default:  res_o = '0;
    endcase
  end

endmodule

// File: rtl/md_unit_e.sv
// E-stage multiply/divide unit: owns HI/LO, runs a fixed-latency busy period
// per long op and raises the stall request for the hazard unit.
module md_unit_e
  import md_unit_e_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             md_stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] pend_q, pend_d, calc_res;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               last_cyc, accept;

  md_unit_e_calc #(.WIDTH(WIDTH)) u_calc (
    .op_i  (md_op),
    .rs_i  (rs_val),
    .rt_i  (rt_val),
    .res_o (calc_res)
  );

  // The commit cycle also accepts a new op so back-to-back long ops hand off
  // without a bubble; an MTHI/MTLO there lands after the commit.
  assign last_cyc = (state_q == ST_BUSY) && (cnt_q == CNT_W'(1));
  assign accept   = start && ((state_q == ST_IDLE) || last_cyc);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == ST_BUSY) begin
      if (last_cyc) begin
        hi_d    = pend_q[2*WIDTH-1:WIDTH];
        lo_d    = pend_q[WIDTH-1:0];
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
    if (accept) begin
      if (is_long_op(md_op)) begin
        pend_d  = calc_res;
        cnt_d   = is_mult_op(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        state_d = ST_BUSY;
      end else if (md_op == MD_MTHI) begin
        hi_d = rs_val;
      end else if (md_op == MD_MTLO) begin
        lo_d = rs_val;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q == ST_BUSY);
  assign md_stall = busy | (start & is_long_op(md_op));
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_md_unit_e.sv
// Directed bench for md_unit_e: table of single ops plus hand-written
// sequences for ignored starts, mid-op reset and back-to-back handoff.
module tb_md_unit_e;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val, hi, lo;
  logic        busy, md_stall;

  md_unit_e #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .md_stall(md_stall),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs, rt, exp_hi, exp_lo;
    int          cyc;
    logic        stall;
  } vec_t;

  vec_t vecs[14];
  int   n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Counts edges while busy (sampled #1 after each edge); flags any HI/LO change.
  task automatic wait_idle(input logic [31:0] ph, input logic [31:0] pl,
                           output int cyc, output logic glitch);
    cyc = 0;
    glitch = 1'b0;
    while (busy && cyc < 50) begin
      if (hi !== ph || lo !== pl) glitch = 1'b1;
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int          cyc;
    logic        gl;
    logic [31:0] ph, pl;

    vecs[0]  = '{3'd1, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 5,  1'b1};
    vecs[1]  = '{3'd4, 32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 32'h0FFF_FFFF, 10, 1'b1};
    vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b1};
    vecs[3]  = '{3'd3, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF, 10, 1'b1};
    vecs[4]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 10, 1'b1};
    vecs[5]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5,  1'b1};
    vecs[6]  = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10, 1'b1};
    vecs[7]  = '{3'd4, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF, 10, 1'b1};
    vecs[8]  = '{3'd1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 32'h8000_0000, 5, 1'b1};
    vecs[9]  = '{3'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        5,  1'b1};
    vecs[10] = '{3'd5, 32'h1234,      32'hAAAA,     32'h0000_1234, 32'h0,         0,  1'b0};
    vecs[11] = '{3'd6, 32'h5678,      32'hBBBB,     32'h0000_1234, 32'h0000_5678, 0,  1'b0};
    vecs[12] = '{3'd0, 32'hDEAD,      32'hBEEF,     32'h0000_1234, 32'h0000_5678, 0,  1'b0};
    vecs[13] = '{3'd7, 32'hDEAD,      32'hBEEF,     32'h0000_1234, 32'h0000_5678, 0,  1'b0};

    reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = '0; rt_val = '0;
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_stall", {63'd0, md_stall}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      start = 1'b1; md_op = vecs[i].op; rs_val = vecs[i].rs; rt_val = vecs[i].rt;
      #1 chk($sformatf("v%0d_stall", i), {63'd0, md_stall}, {63'd0, vecs[i].stall});
      ph = hi; pl = lo;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      if (vecs[i].cyc > 0) ph = hi;
      if (vecs[i].cyc > 0) pl = lo;
      wait_idle(ph, pl, cyc, gl);
      chk($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vecs[i].cyc));
      chk($sformatf("v%0d_hold", i), {63'd0, gl}, 64'd0);
      chk($sformatf("v%0d_hilo", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
    end

    // MTLO issued while a MULT is busy must be ignored.
    @(negedge clk);
    start = 1'b1; md_op = 3'd1; rs_val = 32'd3; rt_val = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; md_op = 3'd6; rs_val = 32'hDEAD;
    #1 chk("mtlo_busy_stall", {63'd0, md_stall}, 64'd1);
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    chk("mtlo_busy_held", {hi, lo}, {32'h1234, 32'h5678});
    wait_idle(32'h1234, 32'h5678, cyc, gl);
    chk("mtlo_busy_cycles", 64'(cyc), 64'd4);
    chk("mtlo_busy_hilo", {hi, lo}, {32'h0, 32'hC});

    // Reset pulsed during busy cycle 3 of a MULTU aborts it.
    @(negedge clk);
    start = 1'b1; md_op = 3'd2; rs_val = 32'hFFFF_FFFF; rt_val = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_commit", {31'd0, busy, hi}, 64'd0);
    chk("abort_lo", {32'd0, lo}, 64'd0);

    // Back-to-back: DIVU started on the MULT commit edge.
    @(negedge clk);
    start = 1'b1; md_op = 3'd1; rs_val = 32'd6; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; md_op = 3'd4; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    chk("b2b_handoff_busy", {63'd0, busy}, 64'd1);
    chk("b2b_mult_commit", {hi, lo}, {32'd0, 32'd42});
    wait_idle(32'd0, 32'd42, cyc, gl);
    chk("b2b_total_busy", 64'(cyc + 5), 64'd15);
    chk("b2b_hold", {63'd0, gl}, 64'd0);
    chk("b2b_divu_hilo", {hi, lo}, {32'd2, 32'd14});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
